// File: rtl/mul2vector4x1.sv
// Pipelined signed dot product of a 1x4 row vector and a 4x1 column vector (5-bit elements, 12-bit result).
// Define MUL2VECTOR4X1_INREG_EN to add an input register stage (latency 3 instead of 2).
module mul2vector4x1 (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic signed [4:0]   A0,
  input  logic signed [4:0]   A1,
  input  logic signed [4:0]   A2,
  input  logic signed [4:0]   A3,
  input  logic signed [4:0]   B0,
  input  logic signed [4:0]   B1,
  input  logic signed [4:0]   B2,
  input  logic signed [4:0]   B3,
  output logic signed [11:0]  OUT,
  output logic                out_valid
);

  // Both operands are widened before multiplying so the product is formed at full 10-bit width.
  function automatic logic signed [9:0] smul(input logic signed [4:0] a, input logic signed [4:0] b);
    logic signed [9:0] ax;
    logic signed [9:0] bx;
    ax = 10'(a);
    bx = 10'(b);
    return ax * bx;
  endfunction

  logic [3:0][4:0] a_s;
  logic [3:0][4:0] b_s;
  logic            v_s;

`ifdef MUL2VECTOR4X1_INREG_EN
  // NOTE: synchronous reset is tested inside the clocked block, so rst only acts on a rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_s <= '0;
      b_s <= '0;
      v_s <= 1'b0;
    end else begin
      a_s <= {A3, A2, A1, A0};
      b_s <= {B3, B2, B1, B0};
      v_s <= in_valid;
    end
  end
`else
  assign a_s = {A3, A2, A1, A0};
  assign b_s = {B3, B2, B1, B0};
  assign v_s = in_valid;
`endif

  logic signed [9:0] p0_d, p1_d, p2_d, p3_d;
  logic signed [9:0] p0_q, p1_q, p2_q, p3_q;
  logic              v1_q;

  always_comb begin
    p0_d = smul($signed(a_s[0]), $signed(b_s[0]));
    p1_d = smul($signed(a_s[1]), $signed(b_s[1]));
    p2_d = smul($signed(a_s[2]), $signed(b_s[2]));
    p3_d = smul($signed(a_s[3]), $signed(b_s[3]));
  end

  // NOTE: state registers use non-blocking assignments so every stage samples the previous cycle's values.
  always_ff @(posedge clk) begin
    if (rst) begin
      p0_q <= '0;
      p1_q <= '0;
      p2_q <= '0;
      p3_q <= '0;
      v1_q <= 1'b0;
    end else begin
      v1_q <= v_s;
      if (v_s) begin
        p0_q <= p0_d;
        p1_q <= p1_d;
        p2_q <= p2_d;
        p3_q <= p3_d;
      end
    end
  end

  // Sum range is -960..1024, so 12 bits never overflow.
  logic signed [11:0] sum_d;

  always_comb begin
    sum_d = 12'(p0_q) + 12'(p1_q) + 12'(p2_q) + 12'(p3_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      OUT       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= v1_q;
      if (v1_q) OUT <= sum_d;
    end
  end

endmodule

// File: tb/tb_mul2vector4x1.sv
// Self-checking bench for mul2vector4x1: directed spec vectors plus randomized traffic against a queue-based model.
// Build with MUL2VECTOR4X1_INREG_EN defined to exercise the input-register variant.
module tb_mul2vector4x1;

`ifdef MUL2VECTOR4X1_INREG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  typedef struct packed {
    logic signed [4:0]  a0, a1, a2, a3;
    logic signed [4:0]  b0, b1, b2, b3;
    logic signed [11:0] expv;
  } vec_t;

  typedef struct {
    int due;
    int val;
  } pend_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic signed [4:0]  a_drv [4];
  logic signed [4:0]  b_drv [4];
  logic signed [11:0] out_w;
  logic               out_valid;

  int checks   = 0;
  int failures = 0;

  // Model state: results waiting for the edge at which they must appear.
  pend_t pend[$];
  int    edge_cnt = 0;
  int    m_out    = 0;
  int    m_ov     = 0;

  mul2vector4x1 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A0        (a_drv[0]),
    .A1        (a_drv[1]),
    .A2        (a_drv[2]),
    .A3        (a_drv[3]),
    .B0        (b_drv[0]),
    .B1        (b_drv[1]),
    .B2        (b_drv[2]),
    .B3        (b_drv[3]),
    .OUT       (out_w),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input integer act, input integer exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int dot(input vec_t x);
    return int'(x.a0) * int'(x.b0) + int'(x.a1) * int'(x.b1)
         + int'(x.a2) * int'(x.b2) + int'(x.a3) * int'(x.b3);
  endfunction

  function automatic vec_t rand_vec();
    vec_t x;
    x.a0 = 5'($urandom); x.a1 = 5'($urandom); x.a2 = 5'($urandom); x.a3 = 5'($urandom);
    x.b0 = 5'($urandom); x.b1 = 5'($urandom); x.b2 = 5'($urandom); x.b3 = 5'($urandom);
    x.expv = '0;
    return x;
  endfunction

  task automatic model_edge(input logic r, input logic v, input vec_t x);
    edge_cnt++;
    if (r) begin
      pend.delete();
      m_out = 0;
      m_ov  = 0;
    end else begin
      m_ov = 0;
      if (pend.size() > 0 && pend[0].due == edge_cnt) begin
        m_out = pend[0].val;
        m_ov  = 1;
        void'(pend.pop_front());
      end
      if (v) pend.push_back('{edge_cnt + LAT - 1, dot(x)});
    end
  endtask

  // One clock: drive inputs, take the edge, update the model, compare 1 time unit later.
  task automatic cycle(input logic r, input logic v, input vec_t x);
    rst      = r;
    in_valid = v;
    a_drv[0] = x.a0; a_drv[1] = x.a1; a_drv[2] = x.a2; a_drv[3] = x.a3;
    b_drv[0] = x.b0; b_drv[1] = x.b1; b_drv[2] = x.b2; b_drv[3] = x.b3;
    @(posedge clk);
    model_edge(r, v, x);
    #1;
    check("model_out", out_w, m_out);
    check("model_ov", out_valid, m_ov);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, rand_vec());
  endtask

  // Issue one vector, wait the pipeline latency, compare against the table constant, then verify hold.
  task automatic run_vec(input string nm, input vec_t x);
    int held;
    cycle(1'b0, 1'b1, x);
    for (int i = 0; i < LAT - 1; i++) begin
      check({nm, "_early_ov"}, out_valid, 0);
      idle();
    end
    check({nm, "_ov"}, out_valid, 1);
    check({nm, "_out"}, out_w, int'(x.expv));
    held = int'(x.expv);
    idle();
    check({nm, "_pulse_end"}, out_valid, 0);
    check({nm, "_hold"}, out_w, held);
  endtask

  vec_t tbl [5];
  int   obs_ov  [8];
  int   obs_out [8];

  initial begin
    tbl[0] = '{5'sd1,   5'sd3,   -5'sd1,  -5'sd5,  5'sd2,   -5'sd2,  5'sd2,   -5'sd5,  12'sd19};
    tbl[1] = '{5'sd1,   5'sd3,   5'sd5,   5'sd5,   5'sd2,   5'sd4,   5'sd2,   5'sd4,   12'sd44};
    tbl[2] = '{-5'sd16, -5'sd16, -5'sd16, -5'sd16, -5'sd16, -5'sd16, -5'sd16, -5'sd16, 12'sd1024};
    tbl[3] = '{-5'sd16, -5'sd16, -5'sd16, -5'sd16, 5'sd15,  5'sd15,  5'sd15,  5'sd15,  -12'sd960};
    tbl[4] = '{5'sd15,  5'sd15,  5'sd15,  5'sd15,  5'sd15,  5'sd15,  5'sd15,  5'sd15,  12'sd900};

    // Reset for 2 cycles, then idle with changing operands: outputs stay 0.
    cycle(1'b1, 1'b0, rand_vec());
    cycle(1'b1, 1'b1, rand_vec());
    for (int i = 0; i < 4; i++) begin
      idle();
      check("rst_idle_out", out_w, 0);
      check("rst_idle_ov", out_valid, 0);
    end

    for (int i = 0; i < 5; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

    // Back-to-back: 19 then 44 on consecutive cycles.
    for (int i = 0; i < LAT + 2; i++) begin
      if (i == 0)      cycle(1'b0, 1'b1, tbl[0]);
      else if (i == 1) cycle(1'b0, 1'b1, tbl[1]);
      else             idle();
      obs_ov[i]  = int'(out_valid);
      obs_out[i] = int'(out_w);
    end
    check("b2b_first_ov", obs_ov[LAT-1], 1);
    check("b2b_first_out", obs_out[LAT-1], 19);
    check("b2b_second_ov", obs_ov[LAT], 1);
    check("b2b_second_out", obs_out[LAT], 44);
    check("b2b_after_ov", obs_ov[LAT+1], 0);

    // Reset one cycle after an accepted operand set drops it.
    cycle(1'b0, 1'b1, tbl[4]);
    cycle(1'b1, 1'b0, rand_vec());
    for (int i = 0; i < LAT + 1; i++) begin
      idle();
      check("midrst_ov", out_valid, 0);
      check("midrst_out", out_w, 0);
    end

    // in_valid together with rst is discarded.
    cycle(1'b1, 1'b1, tbl[2]);
    for (int i = 0; i < LAT + 1; i++) begin
      idle();
      check("rst_iv_ov", out_valid, 0);
    end

    // Randomized traffic with occasional resets, checked against the model every cycle.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 31) == 0), 1'($urandom), rand_vec());
    end
    for (int i = 0; i < LAT + 1; i++) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul2vector4x1.md
MUL2VECTOR4X1 -- requirements
Module: mul2vector4x1

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  A0..A3 and B0..B3 carry a valid operand set this cycle.
REQ-005 A0, A1, A2, A3  input  5 each  signed two's-complement elements of row vector A (1x4).
REQ-006 B0, B1, B2, B3  input  5 each  signed two's-complement elements of column vector B (4x1).
REQ-007 OUT  output  12  signed two's-complement dot product A·B.
REQ-008 out_valid  output  1  OUT holds a new result this cycle.

Function
REQ-009 The block SHALL compute OUT = A0*B0 + A1*B1 + A2*B2 + A3*B3 using signed arithmetic throughout.
REQ-010 Each product SHALL be sign-extended to 10 bits. Each product lies in -240..256.
REQ-011 The products SHALL be summed at 12 bits. The sum lies in -960..1024, so it never overflows and no saturation or wrap logic is needed.
REQ-012 Pipeline stage 1 SHALL register the four 10-bit products and a stage-1 valid bit.
REQ-013 Pipeline stage 2 SHALL register the 12-bit sum into OUT and set out_valid.
REQ-014 Latency SHALL be 2 clock edges from a sampled in_valid=1 to out_valid=1 with the matching OUT.
REQ-015 Throughput SHALL be one operand set per cycle. Back-to-back in_valid pulses SHALL produce back-to-back results in order.
REQ-016 out_valid SHALL be high for exactly one cycle per accepted operand set.
REQ-017 There is no backpressure: results are not stalled.
REQ-018 When no result is produced, OUT SHALL hold its last value and out_valid SHALL be 0.
REQ-019 Operand values sampled while in_valid=0 SHALL NOT affect OUT.

Reset
REQ-020 While rst=1 at a rising edge, OUT SHALL be set to 0, out_valid to 0, and all pipeline registers and valid bits to 0.
REQ-021 in_valid asserted in the same cycle as rst SHALL be discarded.
REQ-022 Reset asserted mid-operation SHALL drop all in-flight results; no out_valid follows for them.
REQ-023 The first operand set accepted after rst deasserts SHALL appear 2 cycles later.

Configuration
REQ-024 Macro MUL2VECTOR4X1_INREG_EN defined: an input register stage captures A0..A3, B0..B3 and in_valid. Latency becomes 3 cycles; the input stage is cleared by rst like the other stages.
REQ-025 Macro MUL2VECTOR4X1_INREG_EN undefined: there is no input register stage and latency is 2 cycles.
REQ-026 All other requirements SHALL hold in both builds, with latency substituted as stated above.

Verification
REQ-027 Apply rst for 2 cycles, then idle -> OUT=0 and out_valid=0 throughout.
REQ-028 Mixed signs: A=(1,3,-1,-5), B=(2,-2,2,-5), in_valid for 1 cycle -> OUT=19 with a single out_valid pulse at latency.
REQ-029 Positive operands: A=(1,3,5,5), B=(2,4,2,4) -> OUT=44. Issue it back-to-back after REQ-028 -> 19 then 44 on consecutive cycles.
REQ-030 Extremes:
- all A=-16 and all B=-16 -> OUT=1024;
- all A=-16 and all B=15 -> OUT=-960;
- all A=15 and all B=15 -> OUT=900.
REQ-031 Change operands while in_valid=0 -> OUT holds its previous value and out_valid stays 0.
REQ-032 Assert rst one cycle after an accepted in_valid -> no out_valid follows and OUT=0. Run this scenario in both macro builds.
